// File: rtl/mul_defs_pkg.sv
// Shared multiplier definitions: FSM state encodings and Booth select codes.
// Latency: n/a (types only).
// Backpressure: n/a.
package mul_defs_pkg;

    // Sequencer states shared by the sequential multiplier variants.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Radix-4 Booth partial-product selection.
    typedef enum logic [2:0] {
        SEL_ZERO = 3'd0,
        SEL_P1   = 3'd1,
        SEL_P2   = 3'd2,
        SEL_M1   = 3'd3,
        SEL_M2   = 3'd4
    } sel_t;

endpackage

// File: rtl/booth_recoder.sv
// Radix-4 Booth recoder: 3-bit window {q1, q0, q_m1} -> partial-product select.
// Latency: combinational.
// Backpressure: none.
// Ports: window (in, 3) = {Q[1], Q[0], q_m1}; sel (out) = select code.
module booth_recoder
    import mul_defs_pkg::*;
(
    input  logic [2:0] window,
    output sel_t       sel
);

    always_comb begin
        sel = SEL_ZERO;
        case (window)
            3'b001, 3'b010: sel = SEL_P1;
            3'b011:         sel = SEL_P2;
            3'b100:         sel = SEL_M2;
            3'b101, 3'b110: sel = SEL_M1;
            default:        sel = SEL_ZERO;   // 000 and 111
        endcase
    end

endmodule

// File: rtl/booth_mul32_seq.sv
// Sequential signed radix-4 Booth multiplier, one bit-pair retired per clock.
// Latency: start at edge k -> busy k+1..k+WIDTH/2, done pulse in k+WIDTH/2+1.
// Backpressure: start is only honoured in IDLE; start while busy/done is dropped.
// Ports: clock, clear (sync, active-high), start, multiplicand/multiplier (signed
//        WIDTH), busy, done (1-cycle registered pulse), product (signed 2*WIDTH,
//        held until the next done or clear).
module booth_mul32_seq
    import mul_defs_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    // Two guard bits on the accumulator so +/-2M of the most negative
    // multiplicand cannot overflow.
    localparam int AW = WIDTH + 2;
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH / 2) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH / 2 - 1);

    state_t             state_q;
    state_t             state_d;
    logic [AW-1:0]      a_q;
    logic [AW-1:0]      m_q;
    logic [WIDTH-1:0]   q_q;
    logic               qm1_q;
    logic [CW-1:0]      cnt_q;
    logic               done_q;
    logic [2*WIDTH-1:0] product_q;

    sel_t               sel;
    logic [AW-1:0]      mag;
    logic               neg;
    logic [AW-1:0]      sum;
    logic [AW-1:0]      a_nxt;
    logic [WIDTH-1:0]   q_nxt;
    logic               qm1_nxt;
    logic               last_iter;

    booth_recoder u_recoder (
        .window ({q_q[1:0], qm1_q}),
        .sel    (sel)
    );

    // Single adder/subtractor: subtraction is invert plus carry-in.
    always_comb begin
        mag = '0;
        neg = 1'b0;
        case (sel)
            SEL_P1: begin mag = m_q;      neg = 1'b0; end
            SEL_P2: begin mag = m_q << 1; neg = 1'b0; end
            SEL_M1: begin mag = m_q;      neg = 1'b1; end
            SEL_M2: begin mag = m_q << 1; neg = 1'b1; end
            default: begin mag = '0;      neg = 1'b0; end
        endcase
        sum = a_q + (mag ^ {AW{neg}}) + {{(AW-1){1'b0}}, neg};
    end

    // Arithmetic shift of {A, Q, q_m1} right by two, replicating A's sign.
    assign a_nxt   = {{2{sum[AW-1]}}, sum[AW-1:2]};
    assign q_nxt   = {sum[1:0], q_q[WIDTH-1:2]};
    assign qm1_nxt = q_q[1];

    assign last_iter = (state_q == ST_RUN) && (cnt_q == LAST);

    // FSM: state register
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (cnt_q == LAST) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clock) begin
        if (clear) begin
            a_q       <= '0;
            m_q       <= '0;
            q_q       <= '0;
            qm1_q     <= 1'b0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            done_q <= last_iter;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        a_q   <= '0;
                        m_q   <= {{2{multiplicand[WIDTH-1]}}, multiplicand};
                        q_q   <= multiplier;
                        qm1_q <= 1'b0;
                        cnt_q <= '0;
                    end
                end
                ST_RUN: begin
                    a_q   <= a_nxt;
                    q_q   <= q_nxt;
                    qm1_q <= qm1_nxt;
                    cnt_q <= cnt_q + CW'(1);
                    // Capture the finished product on the final iteration so it
                    // is already valid in the done cycle.
                    if (cnt_q == LAST) begin
                        product_q <= {a_nxt[WIDTH-1:0], q_nxt};
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy    = (state_q == ST_RUN);
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_booth_mul32_seq.sv
module tb_booth_mul32_seq;

    logic        clock;
    logic        clear;
    logic        start;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic        busy;
    logic        done;
    logic [63:0] product;

    int errors = 0;
    int checks = 0;

    booth_mul32_seq #(.WIDTH(32)) dut (
        .clock        (clock),
        .clear        (clear),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] m;
        logic [31:0] q;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Golden model: plain signed arithmetic on sign-extended operands.
    function automatic logic [63:0] ref_mul(input logic [31:0] m, input logic [31:0] q);
        longint pm;
        longint pq;
        pm = longint'($signed(m));
        pq = longint'($signed(q));
        return 64'(pm * pq);
    endfunction

    // Entered and left at a negedge with the DUT idle. Checks the full
    // latency profile, that product is stable during RUN, and the result.
    // poke_cycle > 0 re-pulses start with other operands in that busy cycle
    // (cycle 17 = the done cycle).
    task automatic run_op(input logic [31:0] m, input logic [31:0] q,
                          input logic [63:0] exp, input string name,
                          input int poke_cycle);
        int lat_bad;
        logic [63:0] prev;
        prev = product;
        lat_bad = 0;
        multiplicand = m;
        multiplier   = q;
        start        = 1'b1;
        @(negedge clock);                    // cycle k+1
        start        = 1'b0;
        multiplicand = $urandom;
        multiplier   = $urandom;
        for (int c = 1; c <= 16; c++) begin
            if (!(busy === 1'b1 && done === 1'b0)) lat_bad++;
            if (product !== prev) lat_bad++;
            if (c == poke_cycle) begin
                start        = 1'b1;
                multiplicand = 32'd9;
                multiplier   = 32'd9;
            end else begin
                start        = 1'b0;
                multiplicand = $urandom;
                multiplier   = $urandom;
            end
            @(negedge clock);
        end
        // cycle k+17
        if (!(busy === 1'b0 && done === 1'b1)) lat_bad++;
        chk({name, " product"}, product, exp);
        if (poke_cycle == 17) begin
            start        = 1'b1;
            multiplicand = 32'd9;
            multiplier   = 32'd9;
        end
        @(negedge clock);                    // cycle k+18
        start = 1'b0;
        if (!(busy === 1'b0 && done === 1'b0)) lat_bad++;
        if (product !== exp) lat_bad++;
        chk({name, " latency"}, 64'(lat_bad), 64'd0);
    endtask

    task automatic idle_watch(input string name, input int ncyc);
        int bad;
        bad = 0;
        for (int c = 0; c < ncyc; c++) begin
            if (busy !== 1'b0 || done !== 1'b0) bad++;
            @(negedge clock);
        end
        chk({name, " stays idle"}, 64'(bad), 64'd0);
    endtask

    initial begin
        logic [31:0] rm;
        logic [31:0] rq;
        int          rsel;

        vecs[0] = '{32'd7,          32'd3,          64'd21};
        vecs[1] = '{32'hFFFF_FFF9,  32'd3,          64'hFFFF_FFFF_FFFF_FFEB};
        vecs[2] = '{32'd0,          32'h1234_5678,  64'd0};
        vecs[3] = '{32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000};
        vecs[4] = '{32'h8000_0000,  32'hFFFF_FFFF,  64'h0000_0000_8000_0000};
        vecs[5] = '{32'h7FFF_FFFF,  32'h7FFF_FFFF,  64'h3FFF_FFFF_0000_0001};
        vecs[6] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'd1};
        vecs[7] = '{32'h8000_0000,  32'h7FFF_FFFF,  64'hC000_0000_8000_0000};

        clear        = 1'b1;
        start        = 1'b0;
        multiplicand = 32'h0;
        multiplier   = 32'h0;
        repeat (3) @(negedge clock);
        chk("reset busy",    64'(busy),  64'd0);
        chk("reset done",    64'(done),  64'd0);
        chk("reset product", product,    64'd0);
        clear = 1'b0;
        @(negedge clock);

        // Start held high while clear is asserted must not launch anything.
        clear = 1'b1;
        start = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        start = 1'b0;
        chk("clear beats start", 64'(busy), 64'd0);
        @(negedge clock);

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].m, vecs[i].q, vecs[i].exp, $sformatf("vec%0d", i), 0);
        end

        // start re-pulsed mid-run with new operands: ignored, single done.
        run_op(32'd5, 32'd6, 64'd30, "poke run", 4);
        idle_watch("poke run", 20);

        // start during the done cycle: ignored.
        run_op(32'd11, 32'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFEA, "poke done", 17);
        idle_watch("poke done", 20);

        // Abort mid-run with clear.
        multiplicand = 32'd5;
        multiplier   = 32'd6;
        start        = 1'b1;
        @(negedge clock);                    // RUN cycle 1
        start = 1'b0;
        repeat (7) @(negedge clock);         // RUN cycle 8
        chk("pre-clear busy", 64'(busy), 64'd1);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        chk("abort busy",    64'(busy), 64'd0);
        chk("abort done",    64'(done), 64'd0);
        chk("abort product", product,   64'd0);
        idle_watch("abort", 24);
        run_op(32'd2, 32'd3, 64'd6, "after abort", 0);

        // Random signed pairs against the golden model, with corner values mixed in.
        for (int n = 0; n < 2000; n++) begin
            rm = $urandom;
            rq = $urandom;
            rsel = $urandom_range(0, 15);
            if (rsel == 0) rm = 32'h8000_0000;
            if (rsel == 1) rq = 32'h8000_0000;
            if (rsel == 2) rq = 32'hFFFF_FFFF;
            if (rsel == 3) rm = 32'h0;
            if (rsel == 4) rm = 32'h7FFF_FFFF;
            run_op(rm, rq, ref_mul(rm, rq), $sformatf("rand%0d", n), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
